// File: rtl/barrel_shift_arbiter_if.sv
// rtl/barrel_shift_arbiter_if.sv - request, response and shared-shifter signals of barrel_shift_arbiter
interface barrel_shift_arbiter_if #(
  parameter int W     = 4,
  parameter int SW    = 2,
  parameter int AMT_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [W-1:0]     req0_data;
  logic [AMT_W-1:0] req0_amt;
  logic             req1_valid;
  logic             req1_ready;
  logic [W-1:0]     req1_data;
  logic [AMT_W-1:0] req1_amt;
  logic [W-1:0]     sh_x;
  logic [SW-1:0]    sh_select;
  logic [W-1:0]     sh_y;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_data;
  logic             rsp_id;
  logic             busy;

  modport slave (
    input  req0_valid, req0_data, req0_amt,
    input  req1_valid, req1_data, req1_amt,
    input  sh_y, rsp_ready,
    output req0_ready, req1_ready,
    output sh_x, sh_select,
    output rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req0_valid, req0_data, req0_amt,
    output req1_valid, req1_data, req1_amt,
    output sh_y, rsp_ready,
    input  req0_ready, req1_ready,
    input  sh_x, sh_select,
    input  rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/barrel_shift_arbiter.sv
// rtl/barrel_shift_arbiter.sv - two-requester arbiter sequencing multi-pass rotations on a shared shifter
// Tie arbitration is round-robin when BSA_ROUND_ROBIN_EN is defined, fixed priority (req0) otherwise.
module barrel_shift_arbiter #(
  parameter int W     = 4,
  parameter int SW    = 2,
  parameter int AMT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  barrel_shift_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PASS = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [AMT_W-1:0] MAXSTEP = AMT_W'(2**SW - 1);

  logic [1:0]       state;
  logic [W-1:0]     acc;
  logic [W-1:0]     rsp_data_q;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] step;
  logic [AMT_W-1:0] rem_next;
  logic             id;
  logic             rsp_id_q;
  logic             grant;
  logic             any_valid;
  logic [W-1:0]     sel_data;
  logic [AMT_W-1:0] sel_amt;

  assign any_valid = bus.req0_valid | bus.req1_valid;

`ifdef BSA_ROUND_ROBIN_EN
  logic last_winner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner <= 1'b1;
    end else if (state == S_IDLE && any_valid) begin
      last_winner <= grant;
    end
  end

  always_comb begin
    if (bus.req0_valid && bus.req1_valid) grant = ~last_winner;
    else                                  grant = ~bus.req0_valid;
  end
`else
  // req1 only wins when req0 is idle
  always_comb grant = ~bus.req0_valid;
`endif

  assign sel_data = grant ? bus.req1_data : bus.req0_data;
  assign sel_amt  = grant ? bus.req1_amt  : bus.req0_amt;

  assign step     = (rem > MAXSTEP) ? MAXSTEP : rem;
  assign rem_next = rem - step;

  assign bus.req0_ready = (state == S_IDLE) && bus.req0_valid && !grant;
  assign bus.req1_ready = (state == S_IDLE) && bus.req1_valid && grant;

  assign bus.sh_x      = (state == S_PASS) ? acc : '0;
  assign bus.sh_select = (state == S_PASS) ? step[SW-1:0] : '0;

  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = (state != S_IDLE);

  // rsp_data/rsp_id are captured on entry to RESP so they survive the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      rem        <= '0;
      id         <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            acc <= sel_data;
            rem <= sel_amt;
            id  <= grant;
            if (sel_amt == '0) begin
              state      <= S_RESP;
              rsp_data_q <= sel_data;
              rsp_id_q   <= grant;
            end else begin
              state <= S_PASS;
            end
          end
        end
        S_PASS: begin
          acc <= bus.sh_y;
          rem <= rem_next;
          if (rem_next == '0) begin
            state      <= S_RESP;
            rsp_data_q <= bus.sh_y;
            rsp_id_q   <= id;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// tb/tb_barrel_shift_arbiter.sv - randomized and directed bench for barrel_shift_arbiter against a transaction model
module tb_barrel_shift_arbiter;

`ifdef BSA_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  barrel_shift_arbiter_if bus ();

  barrel_shift_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [3:0] rotl(input logic [3:0] v, input int n);
    logic [3:0] r;
    r = v;
    for (int i = 0; i < (n % 4); i++) r = {r[2:0], r[3]};
    return r;
  endfunction

  // external combinational shifter
  assign bus.sh_y = rotl(bus.sh_x, int'(bus.sh_select));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // transaction-level model
  bit         m_busy, m_rsp, m_last;
  int         sel_q[$];
  logic [3:0] m_cur, m_pend, m_out_data;
  bit         m_pend_id, m_out_id;
  int         glog[$];

  task automatic m_reset();
    m_busy = 0; m_rsp = 0; m_last = 1;
    sel_q.delete();
    m_cur = 0; m_pend = 0; m_out_data = 0;
    m_pend_id = 0; m_out_id = 0;
  endtask

  function automatic bit m_grant(input bit v0, input bit v1);
    if (v0 && v1) return RR ? !m_last : 1'b0;
    return v0 ? 1'b0 : 1'b1;
  endfunction

  always @(negedge rst_n) m_reset();

  always @(negedge clk) begin
    bit         g;
    logic [3:0] d, a;
    int         rem;
    g = m_grant(bus.req0_valid, bus.req1_valid);
    chk("busy", bus.busy, m_busy);
    chk("rsp_valid", bus.rsp_valid, m_rsp);
    chk("rsp_data", bus.rsp_data, m_out_data);
    chk("rsp_id", bus.rsp_id, m_out_id);
    chk("sh_select", bus.sh_select, sel_q.size() != 0 ? sel_q[0] : 0);
    chk("sh_x", bus.sh_x, sel_q.size() != 0 ? m_cur : 4'd0);
    chk("req0_ready", bus.req0_ready, !m_busy && bus.req0_valid && g == 1'b0);
    chk("req1_ready", bus.req1_ready, !m_busy && bus.req1_valid && g == 1'b1);
    if (rst_n && bus.req0_valid && bus.req0_ready) glog.push_back(0);
    if (rst_n && bus.req1_valid && bus.req1_ready) glog.push_back(1);

    if (!rst_n) begin
      m_reset();
    end else if (sel_q.size() != 0) begin
      m_cur = rotl(m_cur, sel_q.pop_front());
      if (sel_q.size() == 0) begin
        m_rsp = 1; m_out_data = m_pend; m_out_id = m_pend_id;
      end
    end else if (m_rsp) begin
      if (bus.rsp_ready) begin
        m_rsp = 0; m_busy = 0;
      end
    end else if (bus.req0_valid || bus.req1_valid) begin
      d = g ? bus.req1_data : bus.req0_data;
      a = g ? bus.req1_amt  : bus.req0_amt;
      m_busy = 1;
      if (RR) m_last = g;
      m_pend = rotl(d, int'(a));
      m_pend_id = g;
      m_cur = d;
      rem = int'(a);
      while (rem > 0) begin
        sel_q.push_back(rem > 3 ? 3 : rem);
        rem -= (rem > 3 ? 3 : rem);
      end
      if (a == 4'd0) begin
        m_rsp = 1; m_out_data = d; m_out_id = g;
      end
    end
  end

  task automatic send(input int id, input logic [3:0] d, input logic [3:0] a);
    int n;
    n = 0;
    @(posedge clk); #1;
    if (id == 0) begin bus.req0_valid = 1; bus.req0_data = d; bus.req0_amt = a; end
    else         begin bus.req1_valid = 1; bus.req1_data = d; bus.req1_amt = a; end
    do begin
      @(negedge clk);
      n++;
    end while (!(id == 0 ? bus.req0_ready : bus.req1_ready) && n < 50);
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout requester=%0d actual=not_accepted required=accepted", id);
    end
    @(posedge clk); #1;
    if (id == 0) bus.req0_valid = 0; else bus.req1_valid = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit a0, a1;
    m_reset();
    rst_n = 0;
    bus.req0_valid = 0; bus.req0_data = 0; bus.req0_amt = 0;
    bus.req1_valid = 0; bus.req1_data = 0; bus.req1_amt = 0;
    bus.rsp_ready = 1;

    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_sh_x", bus.sh_x, 0);
    chk("rst_sh_select", bus.sh_select, 0);
    @(posedge clk); #3 rst_n = 1;

    // one pass of 1
    send(0, 4'b0001, 4'd1);
    @(negedge clk);
    chk("t1_sel", bus.sh_select, 1);
    chk("t1_early_valid", bus.rsp_valid, 0);
    @(negedge clk);
    chk("t1_valid", bus.rsp_valid, 1);
    chk("t1_data", bus.rsp_data, 4'b0010);
    chk("t1_id", bus.rsp_id, 0);

    // passes of 3 then 2
    send(1, 4'b0001, 4'd5);
    @(negedge clk); chk("t2_sel_a", bus.sh_select, 3);
    @(negedge clk); chk("t2_sel_b", bus.sh_select, 2);
    @(negedge clk);
    chk("t2_valid", bus.rsp_valid, 1);
    chk("t2_data", bus.rsp_data, 4'b0010);
    chk("t2_id", bus.rsp_id, 1);

    // zero amount skips PASS
    send(0, 4'b1000, 4'd0);
    @(negedge clk);
    chk("t3_valid", bus.rsp_valid, 1);
    chk("t3_data", bus.rsp_data, 4'b1000);
    chk("t3_sel", bus.sh_select, 0);

    // continuous ties right after reset
    @(posedge clk); #3 rst_n = 0;
    @(posedge clk); #3 rst_n = 1;
    glog.delete();
    @(posedge clk); #1;
    bus.req0_valid = 1; bus.req0_data = 4'd3; bus.req0_amt = 4'd1;
    bus.req1_valid = 1; bus.req1_data = 4'd5; bus.req1_amt = 4'd2;
    repeat (16) @(posedge clk);
    #1 bus.req0_valid = 0; bus.req1_valid = 0;
    chk("t4_count", glog.size() >= 4, 1);
    if (glog.size() >= 4)
      for (int i = 0; i < 4; i++) chk($sformatf("t4_grant%0d", i), glog[i], RR ? (i % 2) : 0);
    repeat (4) @(posedge clk);

    // response back-pressure
    #1 bus.rsp_ready = 0;
    send(0, 4'b0110, 4'd2);
    bus.req1_valid = 1; bus.req1_data = 4'd9; bus.req1_amt = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_valid", bus.rsp_valid, 1);
    chk("t5_data", bus.rsp_data, 4'b1001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", bus.rsp_valid, 1);
      chk("t5_hold_data", bus.rsp_data, 4'b1001);
      chk("t5_hold_r0", bus.req0_ready, 0);
      chk("t5_hold_r1", bus.req1_ready, 0);
    end
    @(posedge clk); #1 bus.rsp_ready = 1;
    @(negedge clk); chk("t5_still_valid", bus.rsp_valid, 1);
    @(negedge clk);
    chk("t5_idle", bus.busy, 0);
    chk("t5_r1", bus.req1_ready, 1);
    @(posedge clk); #1 bus.req1_valid = 0;
    repeat (3) @(posedge clk);

    // reset mid-PASS
    send(0, 4'b0011, 4'd9);
    @(negedge clk);
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("t6_busy", bus.busy, 0);
    chk("t6_rsp_valid", bus.rsp_valid, 0);
    chk("t6_sh_x", bus.sh_x, 0);
    chk("t6_rsp_data", bus.rsp_data, 0);
    @(posedge clk); #3 rst_n = 1;
    send(0, 4'b0001, 4'd1);
    @(negedge clk); chk("t6_sel", bus.sh_select, 1);
    @(negedge clk);
    chk("t6_valid", bus.rsp_valid, 1);
    chk("t6_data", bus.rsp_data, 4'b0010);

    // random traffic; requesters hold until accepted
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk); #1;
      if (!bus.req0_valid || a0) begin
        bus.req0_valid = 1'($urandom_range(0, 1));
        bus.req0_data  = 4'($urandom);
        bus.req0_amt   = 4'($urandom);
      end
      if (!bus.req1_valid || a1) begin
        bus.req1_valid = 1'($urandom_range(0, 1));
        bus.req1_data  = 4'($urandom);
        bus.req1_amt   = 4'($urandom);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    a0 = bus.req0_valid && bus.req0_ready;
    a1 = bus.req1_valid && bus.req1_ready;
    @(posedge clk); #1;
    if (a0) bus.req0_valid = 0;
    if (a1) bus.req1_valid = 0;
    bus.rsp_ready = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk); #1;
      if (a0) bus.req0_valid = 0;
      if (a1) bus.req1_valid = 0;
    end
    chk("drain_idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
